// File: rtl/morph_pkg.sv
// Shared definitions for the streaming morphology engine.
//   mode_e    : runtime operation select, sampled at frame start
//   state_e   : frame sequencing FSM encoding
//   clog2     : ceil(log2(value)) for counter/pointer widths
//   max_neutral / min_neutral : identity elements of the max/min reductions
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_DILATE = 2'b01,
        MODE_ERODE  = 2'b10,
        MODE_GRAD   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StFlush,
        StDone
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    // Identity for min: all ones at the given pixel width.
    function automatic logic [31:0] min_neutral(input int unsigned dw);
        return (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    endfunction

    // Identity for max: all zeros at any width.
    function automatic logic [31:0] max_neutral(input int unsigned dw);
        return min_neutral(dw) & 32'd0;
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// K-1 chained IMG_W-deep row delays sharing one write/read pointer.
//   vga_ctrl_clk, rst : clock, async active-high reset (pointer only)
//   i_adv             : advance strobe, one pixel pushed per strobe
//   i_data            : pixel entering the newest row
//   o_taps[k]         : pixel pushed k*IMG_W advances ago (k = 0 is i_data)
module morph_line_buffer
    import morph_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned K     = 3
) (
    input  logic                  vga_ctrl_clk,
    input  logic                  rst,
    input  logic                  i_adv,
    input  logic [DW-1:0]         i_data,
    output logic [K-1:0][DW-1:0]  o_taps
);
    localparam int unsigned PTR_W = (IMG_W > 1) ? clog2(IMG_W) : 1;

    logic [DW-1:0]    r_mem [K-1][IMG_W];
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge vga_ctrl_clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == PTR_W'(IMG_W - 1)) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    // Storage is deliberately not reset; stale rows are masked by the row counter.
    always_ff @(posedge vga_ctrl_clk) begin
        if (i_adv) begin
            r_mem[0][r_ptr] <= i_data;
            for (int k = 1; k < K - 1; k++) begin
                r_mem[k][r_ptr] <= r_mem[k-1][r_ptr];
            end
        end
    end

    always_comb begin
        o_taps[0] = i_data;
        for (int k = 1; k < K; k++) begin
            o_taps[k] = r_mem[k-1][r_ptr];
        end
    end

endmodule

// File: rtl/morph_stream_filter.sv
// Streaming grey-scale morphology engine (PASS / DILATE / ERODE / GRADIENT) over a KxK window.
//   vga_ctrl_clk, rst  : clock, async active-high reset
//   enable             : level; high starts/continues a frame, low aborts
//   mode               : operation, latched at frame start
//   s_valid/s_data/s_ready : raster-order input stream
//   m_valid/m_data/m_ready : raster-order output stream, output (r,c) centred on input (r,c)
//   busy               : frame in progress
//   done               : one-cycle pulse after the last output is accepted
module morph_stream_filter
    import morph_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned K     = 3
) (
    input  logic          vga_ctrl_clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          busy,
    output logic          done
);
    localparam int unsigned R      = (K - 1) / 2;
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned NPAD   = R * IMG_W + R;
    localparam int unsigned CNT_W  = clog2(NPIX + NPAD + 1);
    localparam int unsigned COL_W  = (IMG_W > 1) ? clog2(IMG_W) : 1;
    localparam int unsigned ROW_W  = (IMG_H > 1) ? clog2(IMG_H) : 1;
    localparam logic [DW-1:0] MAX_ID = DW'(max_neutral(DW));
    localparam logic [DW-1:0] MIN_ID = DW'(min_neutral(DW));

    state_e                  r_state, w_state_d;
    mode_e                   r_mode;
    logic                    r_rearm;
    logic [CNT_W-1:0]        r_push_cnt, r_out_cnt;
    logic [ROW_W-1:0]        r_q_row, r_w_row;
    logic [COL_W-1:0]        r_q_col, r_w_col;
    logic                    r_w_valid, r_m_valid;
    logic [DW-1:0]           r_m_data;
    logic [K-1:0][K-1:0][DW-1:0] r_win;  // [row k: 0 newest][col j: 0 newest]

    logic                    w_active, w_in_phase, w_stall, w_push, w_center_ok;
    logic                    w_last_in, w_last_out, w_start, w_abort;
    logic [DW-1:0]           w_lb_data, w_max, w_min, w_red;
    logic [K-1:0][DW-1:0]    w_taps;

    assign w_active    = (r_state == StFill) || (r_state == StRun) || (r_state == StFlush);
    assign w_in_phase  = (r_state == StFill) || (r_state == StRun);
    assign w_stall     = r_m_valid && !m_ready;
    // Inputs during FILL/RUN; internal padding pushes during FLUSH until the window drains.
    assign w_push      = !w_stall && (w_in_phase ? s_valid
                                    : (r_state == StFlush) && (r_push_cnt != CNT_W'(NPIX + NPAD)));
    assign w_center_ok = r_push_cnt >= CNT_W'(NPAD);
    assign w_last_in   = w_push && (r_push_cnt == CNT_W'(NPIX - 1));
    assign w_last_out  = r_m_valid && m_ready && (r_out_cnt == CNT_W'(NPIX - 1));
    assign w_lb_data   = (r_state == StFlush) ? '0 : s_data;
    assign w_start     = (r_state == StIdle) && (w_state_d == StFill);
    assign w_abort     = w_active && !enable;

    assign s_ready = w_in_phase && !w_stall;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign busy    = w_active;
    assign done    = (r_state == StDone);

    morph_line_buffer #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .K     (K)
    ) u_line_buffer (
        .vga_ctrl_clk (vga_ctrl_clk),
        .rst          (rst),
        .i_adv        (w_push),
        .i_data       (w_lb_data),
        .o_taps       (w_taps)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (enable && !r_rearm) w_state_d = StFill;
            StFill: begin
                if (w_last_in) w_state_d = StFlush;
                else if (w_push && (r_push_cnt == CNT_W'(NPAD))) w_state_d = StRun;
            end
            StRun:   if (w_last_in) w_state_d = StFlush;
            StFlush: if (w_last_out) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (w_abort) w_state_d = StIdle;
    end

    always_ff @(posedge vga_ctrl_clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // Taps outside the image (by row/column position of the centre) take the neutral value.
    always_comb begin
        int v_row;
        int v_col;
        v_row = 0;
        v_col = 0;
        w_max = MAX_ID;
        w_min = MIN_ID;
        for (int k = 0; k < K; k++) begin
            for (int j = 0; j < K; j++) begin
                v_row = int'(r_w_row) + int'(R) - k;
                v_col = int'(r_w_col) + int'(R) - j;
                if (v_row >= 0 && v_row < int'(IMG_H) && v_col >= 0 && v_col < int'(IMG_W)) begin
                    if (r_win[k][j] > w_max) w_max = r_win[k][j];
                    if (r_win[k][j] < w_min) w_min = r_win[k][j];
                end
            end
        end
    end

    always_comb begin
        w_red = r_win[R][R];
        unique case (r_mode)
            MODE_PASS:   w_red = r_win[R][R];
            MODE_DILATE: w_red = w_max;
            MODE_ERODE:  w_red = w_min;
            MODE_GRAD:   w_red = w_max - w_min;
            default:     w_red = r_win[R][R];
        endcase
    end

    always_ff @(posedge vga_ctrl_clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MODE_PASS;
            r_rearm    <= 1'b0;
            r_push_cnt <= '0;
            r_out_cnt  <= '0;
            r_q_row    <= '0;
            r_q_col    <= '0;
            r_w_row    <= '0;
            r_w_col    <= '0;
            r_w_valid  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_win      <= '0;
        end else begin
            // A finished frame must see enable low before another may start.
            if (r_state == StDone) r_rearm <= 1'b1;
            else if (!enable)      r_rearm <= 1'b0;

            if (w_start) begin
                r_mode     <= mode_e'(mode);
                r_push_cnt <= '0;
                r_out_cnt  <= '0;
                r_q_row    <= '0;
                r_q_col    <= '0;
                r_w_valid  <= 1'b0;
                r_m_valid  <= 1'b0;
            end else if (w_abort) begin
                r_w_valid <= 1'b0;
                r_m_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_push_cnt <= r_push_cnt + CNT_W'(1);
                    for (int k = 0; k < K; k++) begin
                        r_win[k] <= {r_win[k][K-2:0], w_taps[k]};
                    end
                    r_w_valid <= w_center_ok;
                    if (w_center_ok) begin
                        r_w_row <= r_q_row;
                        r_w_col <= r_q_col;
                        if (r_q_col == COL_W'(IMG_W - 1)) begin
                            r_q_col <= '0;
                            r_q_row <= (r_q_row == ROW_W'(IMG_H - 1)) ? '0 : r_q_row + ROW_W'(1);
                        end else begin
                            r_q_col <= r_q_col + COL_W'(1);
                        end
                    end
                end else if (!w_stall) begin
                    r_w_valid <= 1'b0;
                end
                if (!w_stall) begin
                    r_m_valid <= r_w_valid;
                    if (r_w_valid) r_m_data <= w_red;
                end
                if (r_m_valid && m_ready) r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
        end
    end

endmodule
